cnn_core: RTL and testbench

CNN_CORE -- requirements
Module: cnn_core

---
 rtl/cnn_core_pkg.sv | 31 +++
 rtl/l0_fifo.sv | 60 ++++++
 rtl/cnn_core.sv | 160 ++++++++++++++++
 tb/tb_cnn_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_core_pkg.sv
// ============================================================================
// Module : cnn_core_pkg
// Brief  : Shared defaults, command bit positions and storage depths for cnn_core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_core_pkg;

    localparam int C_BW      = 4;
    localparam int C_PSUM_BW = 32;
    localparam int C_ROW     = 8;
    localparam int C_COL     = 8;
    localparam int C_LEN_NIJ = 16;

    localparam int C_INST_LOAD      = 0;
    localparam int C_INST_EXECUTE   = 1;
    localparam int C_INST_L0_WR     = 2;
    localparam int C_INST_L0_RD     = 3;
    localparam int C_INST_FINAL_RD  = 4;
    localparam int C_INST_RCHIP     = 5;
    localparam int C_INST_MEM_WRITE = 6;
    localparam int C_INST_W         = 7;

    localparam int C_SRAM_DEPTH = 2048;
    localparam int C_SRAM_AW    = 11;
    localparam int C_FIFO_DEPTH = 64;

endpackage

`default_nettype wire

// File: rtl/l0_fifo.sv
// ============================================================================
// Module : l0_fifo
// Brief  : L0 word FIFO with show-ahead head; overflow pushes and empty pops are dropped.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l0_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                       (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;
    assign o_dout    = w_empty ? '0 : r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset && w_do_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnn_core.sv
// ============================================================================
// Module : cnn_core
// Brief  : SRAM-fed weight-stationary MAC row with ping-pong psum banks.
//          Optional macro CNN_CORE_RELU_EN clamps read-out columns at zero.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_core
    import cnn_core_pkg::*;
#(
    parameter int bw      = C_BW,
    parameter int psum_bw = C_PSUM_BW,
    parameter int row     = C_ROW,
    parameter int col     = C_COL,
    parameter int len_nij = C_LEN_NIJ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C_INST_W-1:0]      inst,
    input  logic                     wen_act_wgt,
    input  logic                     cen_act_wgt,
    input  logic [row*bw-1:0]        din_act_wgt,
    input  logic [C_SRAM_AW-1:0]     addr_act_wgt,
    output logic [psum_bw*col-1:0]   final_psum_vector
);

    localparam int C_WORD_W = row * bw;
    localparam int C_VEC_W  = psum_bw * col;
    localparam int C_LCW    = $clog2(col);
    localparam int C_NCW    = $clog2(len_nij);
    localparam logic [C_LCW-1:0] C_LOAD_LAST = C_LCW'(col - 1);
    localparam logic [C_NCW-1:0] C_NIJ_LAST  = C_NCW'(len_nij - 1);

    logic [C_WORD_W-1:0] r_sram [0:C_SRAM_DEPTH-1];
    logic [C_WORD_W-1:0] r_sram_q;
    logic [C_WORD_W-1:0] r_wcol [0:col-1];
    logic [C_VEC_W-1:0]  r_bank [0:1][0:len_nij-1];
    logic [C_VEC_W-1:0]  r_final;
    logic [C_LCW-1:0]    r_load_cnt;
    logic [C_NCW-1:0]    r_exec_cnt;
    logic [C_NCW-1:0]    r_clr_cnt;
    logic [C_NCW-1:0]    r_rd_cnt;

    logic [C_WORD_W-1:0] w_l0_q;
    logic [C_VEC_W-1:0]  w_prev_entry;
    logic [C_VEC_W-1:0]  w_rd_entry;
    logic [C_VEC_W-1:0]  w_sum;
    logic [C_VEC_W-1:0]  w_final;
    logic                w_rchip;
    logic                w_wload;
    logic                w_exec;
    logic                w_clear;
    logic                w_fread;

    assign w_rchip = inst[C_INST_RCHIP];
    assign w_wload = inst[C_INST_L0_RD] && inst[C_INST_LOAD];
    assign w_exec  = inst[C_INST_L0_RD] && inst[C_INST_EXECUTE] && !inst[C_INST_LOAD];
    assign w_clear = inst[C_INST_MEM_WRITE];
    assign w_fread = inst[C_INST_FINAL_RD];

    assign final_psum_vector = r_final;

    // Unsigned activation times signed weight, summed with wrap-around.
    function automatic logic [psum_bw-1:0] f_mac(input logic [C_WORD_W-1:0] act,
                                                 input logic [C_WORD_W-1:0] wgt);
        logic [psum_bw-1:0] v_acc;
        logic [psum_bw-1:0] v_a;
        logic [psum_bw-1:0] v_w;
        v_acc = '0;
        for (int r = 0; r < row; r++) begin
            v_a   = {{(psum_bw-bw){1'b0}}, act[r*bw +: bw]};
            v_w   = {{(psum_bw-bw){wgt[r*bw+bw-1]}}, wgt[r*bw +: bw]};
            v_acc = v_acc + v_a * v_w;
        end
        return v_acc;
    endfunction

    always_ff @(posedge clk) begin
        if (!cen_act_wgt) begin
            if (!wen_act_wgt) begin
                r_sram[addr_act_wgt] <= din_act_wgt;
            end else begin
                r_sram_q <= r_sram[addr_act_wgt];
            end
        end
    end

    l0_fifo #(
        .WIDTH (C_WORD_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_l0_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (inst[C_INST_L0_WR]),
        .i_pop  (inst[C_INST_L0_RD]),
        .i_din  (r_sram_q),
        .o_dout (w_l0_q)
    );

    assign w_prev_entry = r_bank[~w_rchip][r_exec_cnt];
    assign w_rd_entry   = r_bank[w_rchip][r_rd_cnt];

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [psum_bw-1:0] w_out;
        logic [psum_bw-1:0] w_rd_col;
        assign w_out    = f_mac(w_l0_q, r_wcol[c]);
        assign w_rd_col = w_rd_entry[c*psum_bw +: psum_bw];
        assign w_sum[c*psum_bw +: psum_bw] = w_prev_entry[c*psum_bw +: psum_bw] + w_out;
`ifdef CNN_CORE_RELU_EN
        assign w_final[c*psum_bw +: psum_bw] = w_rd_col[psum_bw-1] ? '0 : w_rd_col;
`else
        assign w_final[c*psum_bw +: psum_bw] = w_rd_col;
`endif
    end

    // Bank contents deliberately survive reset so accumulation spans reset pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_exec) begin
                r_bank[w_rchip][r_exec_cnt] <= w_sum;
            end
            if (w_clear) begin
                r_bank[0][r_clr_cnt] <= '0;
                r_bank[1][r_clr_cnt] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_load_cnt <= '0;
            r_exec_cnt <= '0;
            r_clr_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_final    <= '0;
            for (int k = 0; k < col; k++) begin
                r_wcol[k] <= '0;
            end
        end else begin
            if (w_wload) begin
                r_wcol[r_load_cnt] <= w_l0_q;
                r_load_cnt <= (r_load_cnt == C_LOAD_LAST) ? '0 : r_load_cnt + 1'b1;
            end
            if (w_exec) begin
                r_exec_cnt <= (r_exec_cnt == C_NIJ_LAST) ? '0 : r_exec_cnt + 1'b1;
            end
            if (w_clear) begin
                r_clr_cnt <= (r_clr_cnt == C_NIJ_LAST) ? '0 : r_clr_cnt + 1'b1;
            end
            if (w_fread) begin
                r_final  <= w_final;
                r_rd_cnt <= (r_rd_cnt == C_NIJ_LAST) ? '0 : r_rd_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_core.sv
// ============================================================================
// Module : tb_cnn_core
// Brief  : Directed self-checking bench for cnn_core (honours CNN_CORE_RELU_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_core;

    localparam logic [6:0] C_LOAD  = 7'h01;
    localparam logic [6:0] C_EXEC  = 7'h02;
    localparam logic [6:0] C_WR    = 7'h04;
    localparam logic [6:0] C_RD    = 7'h08;
    localparam logic [6:0] C_FREAD = 7'h10;
    localparam logic [6:0] C_RCHIP = 7'h20;
    localparam logic [6:0] C_MWR   = 7'h40;

    logic         clk;
    logic         reset;
    logic [6:0]   inst;
    logic         wen_act_wgt;
    logic         cen_act_wgt;
    logic [31:0]  din_act_wgt;
    logic [10:0]  addr_act_wgt;
    logic [255:0] final_psum_vector;

    int checks;
    int errors;

    cnn_core u_dut (
        .clk               (clk),
        .reset             (reset),
        .inst              (inst),
        .wen_act_wgt       (wen_act_wgt),
        .cen_act_wgt       (cen_act_wgt),
        .din_act_wgt       (din_act_wgt),
        .addr_act_wgt      (addr_act_wgt),
        .final_psum_vector (final_psum_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_col(input int v);
`ifdef CNN_CORE_RELU_EN
        return (v < 0) ? 32'd0 : 32'(v);
`else
        return 32'(v);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [6:0] i);
        inst = i;
        step();
        inst = '0;
    endtask

    task automatic sram_wr(input logic [10:0] a, input logic [31:0] d);
        cen_act_wgt = 1'b0; wen_act_wgt = 1'b0; addr_act_wgt = a; din_act_wgt = d;
        step();
        cen_act_wgt = 1'b1; wen_act_wgt = 1'b1;
    endtask

    task automatic sram_rd(input logic [10:0] a);
        cen_act_wgt = 1'b0; wen_act_wgt = 1'b1; addr_act_wgt = a;
        step();
        cen_act_wgt = 1'b1;
    endtask

    task automatic store_push(input logic [10:0] a, input logic [31:0] d);
        sram_wr(a, d);
        sram_rd(a);
        cmd(C_WR);
    endtask

    task automatic do_reset(input logic [6:0] i);
        reset = 1'b0;
        inst  = i;
        step();
        step();
        reset = 1'b1;
        inst  = '0;
    endtask

    task automatic clear_banks();
        repeat (16) cmd(C_MWR);
    endtask

    task automatic load_weights(input logic [31:0] w [8]);
        for (int k = 0; k < 8; k++) store_push(11'h400 + 11'(k), w[k]);
        repeat (8) cmd(C_LOAD | C_RD);
    endtask

    task automatic load_ones();
        logic [31:0] w [8];
        for (int k = 0; k < 8; k++) w[k] = 32'h1111_1111;
        load_weights(w);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inst  = C_FREAD | C_MWR | C_RD | C_EXEC;
        step();
        step();
        checks++;
        if (final_psum_vector !== 256'd0) begin
            errors++;
            $display("FAIL reset_out got %h exp 0", final_psum_vector);
        end
        reset = 1'b1;
        inst  = '0;
    endtask

    task automatic test_basic();
        do_reset('0);
        clear_banks();
        load_ones();
        store_push(11'h000, 32'h1111_1111);
        cmd(C_EXEC | C_RD);
        do_reset('0);
        cmd(C_FREAD);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (final_psum_vector[c*32 +: 32] !== exp_col(8)) begin
                errors++;
                $display("FAIL basic col%0d got %0d exp 8", c,
                         $signed(final_psum_vector[c*32 +: 32]));
            end
        end
    endtask

    task automatic load_signed();
        logic [31:0] w [8];
        logic [3:0]  nib;
        for (int c = 0; c < 8; c++) begin
            nib  = (c >= 4) ? 4'(c - 8) : 4'(c);
            w[c] = {8{nib}};
        end
        load_weights(w);
    endtask

    task automatic test_signed_two_pass();
        int v [8];
        for (int c = 0; c < 8; c++) v[c] = (c >= 4) ? c - 8 : c;
        do_reset('0);
        clear_banks();
        load_signed();
        store_push(11'h001, 32'hFFFF_FFFF);
        cmd(C_EXEC | C_RD);
        do_reset('0);
        cmd(C_FREAD);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (final_psum_vector[c*32 +: 32] !== exp_col(120 * v[c])) begin
                errors++;
                $display("FAIL signed col%0d got %0d exp %0d", c,
                         $signed(final_psum_vector[c*32 +: 32]), $signed(exp_col(120 * v[c])));
            end
        end
        // Reset with every command bit set must not touch the banks.
        do_reset(7'h7F);
        load_signed();
        store_push(11'h001, 32'hFFFF_FFFF);
        cmd(C_EXEC | C_RD | C_RCHIP);
        do_reset(7'h7F);
        cmd(C_FREAD | C_RCHIP);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (final_psum_vector[c*32 +: 32] !== exp_col(240 * v[c])) begin
                errors++;
                $display("FAIL two_pass col%0d got %0d exp %0d", c,
                         $signed(final_psum_vector[c*32 +: 32]), $signed(exp_col(240 * v[c])));
            end
        end
        do_reset('0);
        cmd(C_FREAD);
        checks++;
        if (final_psum_vector[5*32 +: 32] !== exp_col(-360)) begin
            errors++;
            $display("FAIL bank0_kept col5 got %0d exp %0d",
                     $signed(final_psum_vector[5*32 +: 32]), $signed(exp_col(-360)));
        end
    endtask

    task automatic test_fifo();
        int exp_entry [5];
        exp_entry = '{8, 32, 0, 0, 16};
        do_reset('0);
        clear_banks();
        load_ones();
        for (int k = 0; k < 65; k++) store_push(11'h100 + 11'(k), {8{4'((k % 15) + 1)}});
        cmd(C_EXEC | C_RD);
        repeat (62) cmd(C_RD);
        cmd(C_EXEC | C_RD);
        cmd(C_EXEC | C_RD);
        cmd(C_EXEC | C_RD);
        store_push(11'h200, 32'h2222_2222);
        cmd(C_EXEC | C_RD);
        do_reset('0);
        for (int n = 0; n < 5; n++) begin
            cmd(C_FREAD);
            checks++;
            if (final_psum_vector !== {8{exp_col(exp_entry[n])}}) begin
                errors++;
                $display("FAIL fifo entry%0d got %0d exp %0d", n,
                         $signed(final_psum_vector[31:0]), exp_entry[n]);
            end
        end
    endtask

    task automatic test_clear_read();
        do_reset('0);
        clear_banks();
        for (int n = 0; n < 16; n++) begin
            cmd((n >= 8) ? (C_FREAD | C_RCHIP) : C_FREAD);
            checks++;
            if (final_psum_vector !== 256'd0) begin
                errors++;
                $display("FAIL clear_read entry%0d got %h exp 0", n, final_psum_vector);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset('0);
        clear_banks();
        load_ones();
        sram_wr(11'h010, 32'h1111_1111);
        sram_wr(11'h011, 32'h2222_2222);
        sram_rd(11'h010);
        repeat (16) begin
            cmd(C_WR);
            cmd(C_EXEC | C_RD);
        end
        sram_rd(11'h011);
        cmd(C_WR);
        cmd(C_EXEC | C_RD);
        do_reset('0);
        cmd(C_FREAD);
        checks++;
        if (final_psum_vector !== {8{exp_col(16)}}) begin
            errors++;
            $display("FAIL wrap entry0 got %0d exp 16", $signed(final_psum_vector[31:0]));
        end
        cmd(C_FREAD);
        checks++;
        if (final_psum_vector !== {8{exp_col(8)}}) begin
            errors++;
            $display("FAIL wrap entry1 got %0d exp 8", $signed(final_psum_vector[31:0]));
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        inst         = '0;
        wen_act_wgt  = 1'b1;
        cen_act_wgt  = 1'b1;
        din_act_wgt  = '0;
        addr_act_wgt = '0;
        test_reset();
        test_basic();
        test_signed_two_pass();
        test_fifo();
        test_clear_read();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
